multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Control sequencer for the multi-cycle RV32I core.
- Consumes the opcode field from the instruction decode stage and steps the datapath through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Handles instruction-memory and data-memory request/ready handshakes, detects illegal opcodes and bus timeouts, and counts retired instructions.

Parameters:
- TIMEOUT_CYCLES, 16: maximum consecutive cycles a memory request may wait for ready before trapping (legal range 2..255).
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instruction[6:0] from the instruction register decode
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory access completes this cycle
- imem_req  out  1  fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if branch condition true
- pc_src  out  1  0 = PC+4, 1 = ALU target
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 branch compare, 10 funct decode, 11 pass immediate
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- reg_write  out  1  register file write
- wb_sel  out  2  00 ALU, 01 memory, 10 PC (link)
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky trap indicator
- trap_cause  out  2  01 illegal opcode, 10 bus timeout
- instret  out  INSTRET_W  retired-instruction count

Behaviour:

Reset and output encoding:
- Reset is sampled on the rising clk edge while rst_n = 0.
- Reset values: state = IDLE, instret = 0, trap = 0, trap_cause = 00, wait counter = 0.
- All control outputs decode from state (Moore), except ir_write and pc_write in FETCH, which also depend on imem_ready. Every output is 0 in IDLE.
- rst_n low in any state, including mid-wait, returns the block to IDLE on the next edge.

State transitions:
- IDLE: next state is FETCH, unconditionally.
- FETCH:
  - Drives imem_req = 1.
  - If imem_ready = 1, drives ir_write = 1 and pc_write = 1 (pc_src = 0) in that same cycle, then moves to DECODE.
- DECODE (one cycle): classifies the opcode.
  - Legal: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 0110111 LUI. All legal opcodes move to EXECUTE.
  - Any other opcode moves to TRAP with trap_cause = 01.
  - The opcode class is latched in DECODE. The opcode input is don't-care afterwards.
- EXECUTE (one cycle):
  - R: alu_op = 10, alu_src_b = 0, then WRITEBACK.
  - I-ALU: alu_op = 10, alu_src_b = 1, then WRITEBACK.
  - LUI: alu_op = 11, alu_src_b = 1, then WRITEBACK.
  - LOAD and STORE: alu_op = 00, alu_src_b = 1, then MEM.
  - BRANCH: alu_op = 01, pc_write_cond = 1, pc_src = 1, retire = 1, then FETCH.
  - JAL: alu_op = 00, alu_src_b = 1, pc_write = 1, pc_src = 1, then WRITEBACK.
- MEM:
  - Drives dmem_req = 1, and dmem_we = 1 for STORE.
  - On dmem_ready, LOAD moves to WRITEBACK; STORE pulses retire and moves to FETCH.
- WRITEBACK (one cycle):
  - Drives reg_write = 1 and retire = 1, then FETCH.
  - wb_sel = 01 for LOAD, 10 for JAL, 00 otherwise.
- TRAP:
  - Terminal state; all control outputs are 0 and trap = 1.
  - Only reset exits TRAP. instret is frozen.

Wait counter:
- Cleared on every entry to FETCH and MEM.
- Increments each cycle the request is high and ready is low.
- If ready is low and the counter equals TIMEOUT_CYCLES-1, the next state is TRAP with trap_cause = 10. A request therefore waits at most TIMEOUT_CYCLES cycles.
- Ready takes priority when it is high in the timeout cycle itself.

Other rules:
- instret increments by 1 on each retire pulse and wraps modulo 2^INSTRET_W without a flag.
- Ready signals are ignored in states that do not issue the matching request.
- Latency with zero-wait memory:
  - ALU, LUI, JAL: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.

Test Plan:
1. Reset, then R-type opcode 0110011, imem_ready held high:
   - Required state sequence: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FETCH.
   - reg_write = 1 and retire = 1 only in WRITEBACK; instret = 1 afterwards.
2. LOAD 0000011 with dmem_ready delayed 3 cycles:
   - dmem_req is held for 4 cycles and wb_sel = 01 in WRITEBACK.
   - Total latency is 8 cycles; instret increments once.
3. STORE then BRANCH:
   - STORE: dmem_we = 1 only in MEM, no reg_write, retire pulses in the MEM completion cycle.
   - BRANCH: pc_write_cond = 1 and pc_src = 1 in EXECUTE, 3-cycle instruction.
4. Opcode 1111111:
   - trap = 1 and trap_cause = 01 from the cycle after DECODE.
   - Outputs stay 0 for 20 cycles, instret is unchanged, and reset restores IDLE with trap = 0.
5. imem_ready held low with TIMEOUT_CYCLES = 16:
   - TRAP is entered after exactly 16 FETCH cycles.
   - Repeat with ready asserted on cycle 16: normal DECODE follows and no trap occurs.
6. rst_n driven low mid-MEM:
   - Next state is IDLE, instret = 0, dmem_req drops.
   - Pre-load instret near 2^INSTRET_W-1 (INSTRET_W = 4, 16 instructions): the counter wraps to 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control sequencer for a multi-cycle RV32I core. Steps the datapath through
//   FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK), handles the instruction
//   and data memory request/ready handshakes, traps on illegal opcodes and on
//   memory requests that wait too long, and counts retired instructions.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   opcode[6:0]           instruction[6:0], sampled only in DECODE
//   imem_ready            instruction memory has data this cycle
//   dmem_ready            data memory access completes this cycle
//   imem_req, ir_write    fetch request / instruction register load
//   pc_write, pc_write_cond, pc_src   PC update controls (pc_src 1 = ALU target)
//   alu_src_b, alu_op[1:0]            ALU operand / operation select
//   dmem_req, dmem_we     data memory request / write enable
//   reg_write, wb_sel[1:0]            register write and writeback source
//   retire                one-cycle pulse per completed instruction
//   trap, trap_cause[1:0] sticky trap flag; 01 illegal opcode, 10 bus timeout
//   instret               retired-instruction counter (wraps silently)
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 pc_src,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 retire,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI
  } op_class_t;

  // Last counter value before a still-waiting request traps.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                 state_reg, state_next;
  op_class_t              class_reg, class_next;
  logic [1:0]             trap_cause_reg, trap_cause_next;
  logic                   trap_reg;
  logic [7:0]             wait_cnt_reg;
  logic [INSTRET_W-1:0]   instret_reg;

  op_class_t              dec_class;
  logic                   dec_legal;
  logic                   timeout_hit;

  assign timeout_hit = (wait_cnt_reg == TIMEOUT_LAST);

  // Opcode classification, only consumed in DECODE.
  always_comb begin
    dec_class = C_ALU_R;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: dec_class = C_ALU_R;
      7'b0010011: dec_class = C_ALU_I;
      7'b0000011: dec_class = C_LOAD;
      7'b0100011: dec_class = C_STORE;
      7'b1100011: dec_class = C_BRANCH;
      7'b1101111: dec_class = C_JAL;
      7'b0110111: dec_class = C_LUI;
      default:    dec_legal = 1'b0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_next      = state_reg;
    class_next      = class_reg;
    trap_cause_next = trap_cause_reg;
    imem_req        = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_src          = 1'b0;
    alu_src_b       = 1'b0;
    alu_op          = 2'b00;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    reg_write       = 1'b0;
    wb_sel          = 2'b00;
    retire          = 1'b0;

    case (state_reg)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          // Instruction capture and PC+4 happen in the ready cycle itself.
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next      = S_TRAP;
          trap_cause_next = 2'b10;
        end
      end

      S_DECODE: begin
        if (dec_legal) begin
          class_next = dec_class;
          state_next = S_EXECUTE;
        end else begin
          state_next      = S_TRAP;
          trap_cause_next = 2'b01;
        end
      end

      S_EXECUTE: begin
        case (class_reg)
          C_ALU_R: begin
            alu_op     = 2'b10;
            state_next = S_WRITEBACK;
          end
          C_ALU_I: begin
            alu_op     = 2'b10;
            alu_src_b  = 1'b1;
            state_next = S_WRITEBACK;
          end
          C_LUI: begin
            alu_op     = 2'b11;
            alu_src_b  = 1'b1;
            state_next = S_WRITEBACK;
          end
          C_LOAD, C_STORE: begin
            alu_src_b  = 1'b1;
            state_next = S_MEM;
          end
          C_BRANCH: begin
            // Branch completes here; the PC is updated only if taken.
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            retire        = 1'b1;
            state_next    = S_FETCH;
          end
          default: begin // C_JAL: jump now, write the link register next
            alu_src_b  = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            state_next = S_WRITEBACK;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_reg == C_STORE);
        if (dmem_ready) begin
          if (class_reg == C_STORE) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_next      = S_TRAP;
          trap_cause_next = 2'b10;
        end
      end

      S_WRITEBACK: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
        if (class_reg == C_LOAD)     wb_sel = 2'b01;
        else if (class_reg == C_JAL) wb_sel = 2'b10;
      end

      S_TRAP: state_next = S_TRAP;

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      class_reg      <= C_ALU_R;
      trap_reg       <= 1'b0;
      trap_cause_reg <= 2'b00;
      wait_cnt_reg   <= 8'd0;
      instret_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      class_reg      <= class_next;
      trap_cause_reg <= trap_cause_next;
      trap_reg       <= (state_next == S_TRAP);
      // Counter restarts on each fresh request and only counts stalled cycles.
      if ((state_next != state_reg) &&
          ((state_next == S_FETCH) || (state_next == S_MEM)))
        wait_cnt_reg <= 8'd0;
      else if (((state_reg == S_FETCH) && !imem_ready) ||
               ((state_reg == S_MEM) && !dmem_ready))
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (retire)
        instret_reg <= instret_reg + INSTRET_W'(1);
    end
  end

  assign trap       = trap_reg;
  assign trap_cause = trap_cause_reg;
  assign instret    = instret_reg;

endmodule
